// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opCode map, FSM state
// encoding and the opCode legality check.
package alu_pkg;

  localparam logic [3:0] OpNoop        = 4'd0;
  localparam logic [3:0] OpReset       = 4'd1;
  localparam logic [3:0] OpOr          = 4'd3;
  localparam logic [3:0] OpAnd         = 4'd5;
  localparam logic [3:0] OpAdd         = 4'd6;
  localparam logic [3:0] OpSub         = 4'd8;
  localparam logic [3:0] OpEqual       = 4'd12;
  localparam logic [3:0] OpGreaterThan = 4'd13;
  localparam logic [3:0] OpLessThan    = 4'd14;
  localparam logic [3:0] OpError       = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } sched_state_e;

  // Codes with no ALU implementation are answered by the scheduler itself.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b1;
    case (op)
      4'd2, 4'd4, 4'd7, 4'd9, 4'd10, 4'd11, 4'd15: legal = 1'b0;
      default:                                     legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), returning a one-hot grant and the granted index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  // Scan from ptr upward; the first valid requester wins.
  always_comb begin
    logic          found;
    logic [ID_W-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters. One operation is in
// flight at a time: grant -> hold ALU inputs ALU_LAT cycles -> present response.
// Optional feature macro ALU_ACC_EN adds an accumulator that can replace operand b.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0] req_op,
`ifdef ALU_ACC_EN
  input  logic [NUM_REQ-1:0]   req_use_acc,
`endif
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 rsp_overflow,
  output logic                 rsp_err
);

  sched_state_e      state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [3:0]        cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   g_idx;
  logic [31:0]       g_sel;
  logic [31:0]       win_a;
  logic [31:0]       win_b;
  logic [3:0]        win_op;
  logic              win_legal;
  logic [ID_W-1:0]   ptr_next;

  // Arbitration only while idle and out of reset, so req_ready is zero otherwise.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .en   (reset && (state_q == StIdle)),
    .grant(grant),
    .idx  (g_idx)
  );

  assign req_ready = grant;
  assign g_sel     = 32'(g_idx);
  assign win_a     = req_a[32*g_sel +: 32];
  assign win_op    = req_op[4*g_sel +: 4];
  assign win_legal = op_is_legal(win_op);
  assign ptr_next  = (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + ID_W'(1);

`ifdef ALU_ACC_EN
  logic [31:0] acc_q;

  assign win_b = req_use_acc[g_idx] ? acc_q : req_b[32*g_sel +: 32];

  // Accumulator follows every accepted non-error result; a RESET op clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (state_q == StResp && rsp_ready && !rsp_err) begin
      acc_q <= (alu_op == OpReset) ? '0 : rsp_result;
    end
  end
`else
  assign win_b = req_b[32*g_sel +: 32];
`endif

  // Scheduler FSM with its operand, counter and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OpNoop;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            ptr_q  <= ptr_next;
            rsp_id <= g_idx;
            if (win_legal) begin
              alu_a   <= win_a;
              alu_b   <= win_b;
              alu_op  <= win_op;
              cnt_q   <= 4'(ALU_LAT - 1);
              rsp_err <= 1'b0;
              state_q <= StExec;
            end else begin
              // Unimplemented op: ALU left idle, answer directly with an error.
              alu_op       <= OpNoop;
              rsp_err      <= 1'b1;
              rsp_result   <= '0;
              rsp_zero     <= 1'b0;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_valid    <= 1'b1;
              state_q      <= StResp;
            end
          end
        end
        StExec: begin
          if (cnt_q == 4'd0) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_valid    <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: a grant checker predicts the
// round-robin winner and queues the expected response; a monitor pops and
// compares on every response handshake.
module tb_alu_req_scheduler;
  import alu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LAT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [4*N-1:0]  req_op;
  logic [N-1:0]    req_use_acc;
  logic [31:0]     alu_a, alu_b, alu_result;
  logic [3:0]      alu_op;
  logic            alu_zero, alu_carry, alu_overflow;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero, rsp_carry, rsp_overflow, rsp_err;

  always #5 clk = ~clk;

  alu_req_scheduler #(
    .NUM_REQ(N),
    .ID_W   (IDW),
    .ALU_LAT(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
`ifdef ALU_ACC_EN
    .req_use_acc (req_use_acc),
`endif
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_carry   (rsp_carry),
    .rsp_overflow(rsp_overflow),
    .rsp_err     (rsp_err)
  );

  // Behavioural ALU: returns {overflow, carry, zero, result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0; s = '0;
    case (op)
      OpOr:          r = a | b;
      OpAnd:         r = a & b;
      OpAdd: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OpSub: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OpEqual:       r = {31'd0, a == b};
      OpGreaterThan: r = {31'd0, a > b};
      OpLessThan:    r = {31'd0, a < b};
      default:       r = '0;
    endcase
    return {v, c, (r == 32'd0), r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           z, c, v, err;
    logic [3:0]     op;
    logic [31:0]    a, b;
    int             cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_grants = 0;
  int          ptr_m = 0;
  logic [31:0] acc_m = '0;
  int          stall = 0;
  bit          rdy_rand = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Grant checker: predicts the winner and queues the expected response.
  initial begin
    int          w;
    logic [N-1:0] eg;
    exp_t        e;
    logic [34:0] f;
    forever begin
      @(negedge clk); #1;
      if (reset && req_ready != '0) begin
        w  = pick(req_valid, ptr_m);
        eg = (w < 0) ? '0 : (N'(1) << w);
        chk("grant_onehot", 64'(req_ready), 64'(eg));
        chk("grant_while_busy", 64'(q.size()), 64'd0);
        if (w >= 0) begin
          e.id  = IDW'(w);
          e.a   = req_a[32*w +: 32];
          e.b   = req_b[32*w +: 32];
`ifdef ALU_ACC_EN
          if (req_use_acc[w]) e.b = acc_m;
`endif
          e.op  = req_op[4*w +: 4];
          e.err = e.op inside {4'd2, 4'd4, 4'd7, 4'd9, 4'd10, 4'd11, 4'd15};
          if (e.err) begin
            e.res = '0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0;
          end else begin
            f = alu_fn(e.a, e.b, e.op);
            {e.v, e.c, e.z, e.res} = f;
          end
          e.cyc = cyc + 1 + (e.err ? 0 : int'(LAT));
          q.push_back(e);
          ptr_m = (w + 1) % N;
          n_grants++;
        end
      end
    end
  end

  // Response monitor: latency, stability under backpressure, handshake contents.
  initial begin
    bit          prev;
    logic [37:0] snap;
    exp_t        e;
    prev = 1'b0;
    rsp_ready = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        prev = 1'b0;
      end else begin
        if (rsp_valid && q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else if (rsp_valid) begin
          e = q[0];
          if (!prev) begin
            chk("rsp_latency", 64'(cyc), 64'(e.cyc));
            snap = {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err};
          end else begin
            chk("rsp_stable", {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err},
                64'(snap));
          end
          chk("req_ready_in_resp", 64'(req_ready), 64'd0);
          chk("alu_op", 64'(alu_op), 64'(e.err ? OpNoop : e.op));
          if (!e.err) begin
            chk("alu_a", 64'(alu_a), 64'(e.a));
            chk("alu_b", 64'(alu_b), 64'(e.b));
          end
          if (stall > 0) begin
            stall--;
            rsp_ready = 1'b0;
          end else begin
            rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          if (rsp_ready) begin
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
            chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
            chk("rsp_overflow", 64'(rsp_overflow), 64'(e.v));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            if (!e.err) acc_m = (e.op == OpReset) ? 32'd0 : e.res;
            void'(q.pop_front());
          end
        end else begin
          rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        prev = rsp_valid;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic use_acc);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[4*i +: 4]  = op;
    req_use_acc[i]    = use_acc;
  endtask

  // Presents mask until a grant is seen, then drops the requests after the accept edge.
  task automatic issue(input logic [N-1:0] mask);
    int start;
    bit got;
    start = n_grants;
    got   = 1'b0;
    @(negedge clk);
    req_valid = mask;
    for (int k = 0; k < 60 && !got; k++) begin
      #3;
      if (n_grants != start) got = 1'b1;
      else @(negedge clk);
    end
    chk("grant_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_use_acc = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'(OpNoop));
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_rsp", {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;

    // Round robin, all requesters valid with OR ops: expect ids 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 32'h0f0 << i, 32'h3 << i, OpOr, 1'b0);
    for (int t = 0; t < 5; t++) begin
      issue(4'hf);
      drain();
    end

    // Single ADD 5+7 on requester 0.
    set_req(0, 32'd5, 32'd7, OpAdd, 1'b0);
    issue(4'b0001);
    drain();

    // Illegal op on requester 2.
    set_req(2, 32'h1234, 32'h5678, 4'b0111, 1'b0);
    issue(4'b0100);
    drain();

    // Backpressure: SUB 9-9 held for 5 cycles.
    set_req(1, 32'd9, 32'd9, OpSub, 1'b0);
    stall = 5;
    issue(4'b0010);
    drain();

    // Reset while executing: response dropped, pointer back to 0.
    set_req(0, 32'd1, 32'd2, OpAdd, 1'b0);
    issue(4'b0001);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    @(negedge clk); #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_alu", {alu_op, alu_a[27:0], alu_b[31:0]}, 64'd0);
    chk("midrst_rsp", {rsp_id, rsp_result, rsp_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    acc_m = '0;
    repeat (LAT + 3) @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 32'd100 + i, 32'd1, OpAdd, 1'b0);
    issue(4'hf);
    drain();

`ifdef ALU_ACC_EN
    // Accumulator: 3+4, then 10+acc, then RESET clears acc, then 0+acc.
    set_req(0, 32'd3, 32'd4, OpAdd, 1'b0);
    issue(4'b0001); drain();
    set_req(0, 32'd10, 32'd0, OpAdd, 1'b1);
    issue(4'b0001); drain();
    set_req(0, 32'd0, 32'd0, OpReset, 1'b0);
    issue(4'b0001); drain();
    set_req(0, 32'd0, 32'd99, OpAdd, 1'b1);
    issue(4'b0001); drain();
`endif

    // Random traffic: requests change every cycle, random backpressure.
    rdy_rand = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 3) == 0 ? 32'd9 : $urandom(),
                $urandom_range(0, 3) == 0 ? 32'd9 : $urandom(),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
    end
    @(negedge clk);
    req_valid = '0;
    rdy_rand = 1'b0;
    drain();
    chk("enough_grants", 64'(n_grants > 60), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
